wb_master_req: RTL and testbench

- Synthesizable Wishbone B4 initiator that issues single and incrementing-burst read/write cycles into the SDRAM controller's Wishbone slave port (wb_stb_i/wb_cyc_i/wb_we_i/wb_sel_i/wb_ack_o side).
- It is the requesting end of the Wishbone interface the assertion/cover infrastructure monitors.
- Used as a bench traffic engine and as the front-end for on-chip SDRAM clients.
- Accepts a command descriptor, streams write data or returns read data, and reports done/timeout status.

---
 rtl/wb_master_pkg.sv | 16 +
 rtl/wb_master_req_watchdog.sv | 30 +++
 rtl/wb_master_req.sv | 168 ++++++++++++++++
 tb/tb_wb_master_req.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_master_pkg.sv
// Shared types and constants for the Wishbone B4 request engine.
package wb_master_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    ABORT = 2'd2
  } state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam int ADR_STEP = 4;

endpackage

// File: rtl/wb_master_req_watchdog.sv
// Ack watchdog: counts cycles spent waiting for an acknowledge and flags
// expiry once TIMEOUT-1 consecutive un-acked cycles have elapsed.
module wb_ack_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] r_cnt;

  // Saturates at the expiry value so a stalled enable can never wrap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_expire) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_expire = (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/wb_master_req.sv
// Wishbone B4 initiator: issues single and incrementing-burst read/write
// cycles from a command descriptor, with an ack watchdog that aborts stalls.
module wb_master_req
  import wb_master_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [LEN_W-1:0]  cmd_len_i,
  input  logic [3:0]        cmd_sel_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              wr_pop_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              timeout_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [3:0]        wb_sel_o,
  output logic [2:0]        wb_cti_o,
  output logic [DATA_W-1:0] wb_dat_o,
  input  logic [DATA_W-1:0] wb_dat_i,
  input  logic              wb_ack_i
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_we;
  logic [ADDR_W-1:0]  r_adr;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_beat_cnt;
  logic [3:0]         r_sel;
  logic [DATA_W-1:0]  r_rd_data;
  logic               r_rd_valid;
  logic               r_done;

  logic w_xfer;
  logic w_accept;
  logic w_ack;
  logic w_last;
  logic w_expire;
  logic w_abort;
  logic w_unused_adr_lsb;

  assign w_xfer           = (r_state == XFER);
  assign w_accept         = cmd_valid_i && (r_state == IDLE);
  assign w_ack            = w_xfer && wb_ack_i;
  assign w_last           = (r_beat_cnt == r_len);
  // An ack in the expiry cycle wins over the abort.
  assign w_abort          = w_xfer && !wb_ack_i && w_expire;
  assign w_unused_adr_lsb = ^cmd_addr_i[1:0];

  wb_ack_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .i_clk    (wb_clk_i),
    .i_rst_n  (wb_rst_n_i),
    .i_clr    (!w_xfer || wb_ack_i),
    .i_en     (w_xfer),
    .o_expire (w_expire)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    cmd_ready_o = 1'b0;
    busy_o      = 1'b1;
    wb_cyc_o    = 1'b0;
    wb_stb_o    = 1'b0;
    wb_we_o     = 1'b0;
    wb_cti_o    = CTI_CLASSIC;
    wb_dat_o    = '0;
    wr_pop_o    = 1'b0;
    timeout_o   = 1'b0;
    unique case (r_state)
      IDLE: begin
        cmd_ready_o = 1'b1;
        busy_o      = 1'b0;
        if (cmd_valid_i) begin
          w_state_nxt = XFER;
        end
      end
      XFER: begin
        wb_cyc_o = 1'b1;
        wb_stb_o = 1'b1;
        wb_we_o  = r_we;
        wr_pop_o = wb_ack_i && r_we;
        if (r_we) begin
          wb_dat_o = wr_data_i;
        end
        if (r_len == '0) begin
          wb_cti_o = CTI_CLASSIC;
        end else if (w_last) begin
          wb_cti_o = CTI_EOB;
        end else begin
          wb_cti_o = CTI_INCR;
        end
        if (wb_ack_i && w_last) begin
          w_state_nxt = IDLE;
        end else if (w_abort) begin
          w_state_nxt = ABORT;
        end
      end
      ABORT: begin
        timeout_o   = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Command latch, beat advance and read-return register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_we       <= 1'b0;
      r_adr      <= '0;
      r_len      <= '0;
      r_sel      <= '0;
      r_beat_cnt <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_rd_valid <= w_ack && !r_we;
      r_done     <= w_ack && w_last;
      if (w_ack && !r_we) begin
        r_rd_data <= wb_dat_i;
      end
      if (w_accept) begin
        r_we       <= cmd_we_i;
        r_adr      <= {cmd_addr_i[ADDR_W-1:2], 2'b00};
        r_len      <= cmd_len_i;
        r_sel      <= cmd_sel_i;
        r_beat_cnt <= '0;
      end else if (w_ack && !w_last) begin
        r_adr      <= r_adr + ADDR_W'(ADR_STEP);
        r_beat_cnt <= r_beat_cnt + LEN_W'(1);
      end
    end
  end

  assign wb_adr_o   = r_adr;
  assign wb_sel_o   = r_sel;
  assign rd_data_o  = r_rd_data;
  assign rd_valid_o = r_rd_valid;
  assign done_o     = r_done;

endmodule

// File: tb/tb_wb_master_req.sv
// Self-checking bench for wb_master_req: directed table, corner sequences
// and randomized commands against a transaction-level expectation model.
module tb_wb_master_req;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_we_i = 1'b0;
  logic [31:0] cmd_addr_i = '0;
  logic [7:0]  cmd_len_i = '0;
  logic [3:0]  cmd_sel_i = '0;
  logic [31:0] wr_data_i;
  logic        wr_pop_o;
  logic [31:0] rd_data_o;
  logic        rd_valid_o, busy_o, done_o, timeout_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic [2:0]  wb_cti_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;

  wb_master_req #(.ADDR_W(32), .DATA_W(32), .LEN_W(8), .TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i), .cmd_sel_i(cmd_sel_i),
    .wr_data_i(wr_data_i), .wr_pop_o(wr_pop_o),
    .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
    .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_cti_o(wb_cti_o),
    .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  typedef struct {
    logic [31:0] adr;
    logic [2:0]  cti;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] dat;
    logic        pop;
    int          cyc;
  } beat_t;

  beat_t       q_beats[$];
  logic [31:0] q_rd[$];
  int          q_rd_cyc[$];
  int          q_done[$];
  int          to_cnt;
  int          cyc_high;
  int          clr_req = 0;
  logic        pop_seen = 1'b0;

  int          slv_lat = 0;
  logic [31:0] slv_xor = '0;
  logic [31:0] wr_base = '0;
  int          wr_req = 0;

  // Wishbone slave and FWFT write-data source; updates just after each edge.
  initial begin
    int wait_cnt;
    int idx;
    int seen_req;
    wait_cnt = 0; idx = 0; seen_req = 0;
    wb_ack_i = 1'b0; wb_dat_i = '0; wr_data_i = '0;
    forever begin
      @(posedge clk);
      #1;
      if (seen_req != wr_req) begin
        seen_req = wr_req;
        idx = 0;
      end else if (pop_seen) begin
        idx++;
      end
      wr_data_i = wr_base + 32'(idx);
      if (wb_cyc_o && wb_stb_o) begin
        if (wait_cnt >= slv_lat) begin
          wb_ack_i = 1'b1;
          wb_dat_i = wb_adr_o ^ slv_xor;
          wait_cnt = 0;
        end else begin
          wb_ack_i = 1'b0;
          wait_cnt++;
        end
      end else begin
        wb_ack_i = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  // Bus monitor, sampled on the falling edge.
  initial begin
    int clr_ack;
    clr_ack = 0; to_cnt = 0; cyc_high = 0;
    forever begin
      @(negedge clk);
      if (clr_ack != clr_req) begin
        clr_ack = clr_req;
        q_beats.delete(); q_rd.delete(); q_rd_cyc.delete(); q_done.delete();
        to_cnt = 0; cyc_high = 0;
      end
      pop_seen = wr_pop_o;
      if (wb_cyc_o) cyc_high++;
      if (wb_cyc_o && wb_stb_o && wb_ack_i)
        q_beats.push_back('{wb_adr_o, wb_cti_o, wb_sel_o, wb_we_o, wb_dat_o, wr_pop_o, cyc_n});
      if (rd_valid_o) begin
        q_rd.push_back(rd_data_o);
        q_rd_cyc.push_back(cyc_n);
      end
      if (done_o) q_done.push_back(cyc_n);
      if (timeout_o) to_cnt++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic mon_clear();
    clr_req++;
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [7:0] len,
                       input logic [3:0] sel, output int acc);
    int g;
    g = 0;
    @(negedge clk);
    cmd_valid_i = 1'b1; cmd_we_i = we; cmd_addr_i = addr; cmd_len_i = len; cmd_sel_i = sel;
    while (!cmd_ready_o && g < 3000) begin
      @(negedge clk);
      g++;
    end
    chk("accept_bound", 32'(g < 3000), 32'd1);
    @(posedge clk);
    #1;
    acc = cyc_n;
    cmd_valid_i = 1'b0;
  endtask

  // Expected behaviour derived from the command alone: beat i sits at
  // (addr & ~3) + 4*i, CTI marks single / incrementing / last beat.
  task automatic run_cmd(input logic we, input logic [31:0] addr, input logic [7:0] len,
                         input logic [3:0] sel, input int lat, input logic [31:0] xr,
                         input logic [31:0] wb);
    int beats, acc, g;
    logic [31:0] base, ea;
    logic [2:0]  ec;
    beats = int'(len) + 1;
    slv_lat = lat; slv_xor = xr; wr_base = wb; wr_req++;
    mon_clear();
    issue(we, addr, len, sel, acc);
    g = 0;
    while (q_done.size() == 0 && to_cnt == 0 && g < 3000) begin
      @(negedge clk);
      #1;
      g++;
    end
    chk("cmd_end_bound", 32'(g < 3000), 32'd1);
    repeat (2) @(negedge clk);
    #1;
    if (lat >= TO) begin
      chk("to_pulse", 32'(to_cnt), 32'd1);
      chk("to_no_done", 32'(q_done.size()), 32'd0);
      chk("to_cyc_cycles", 32'(cyc_high), 32'(TO));
      chk("to_no_beats", 32'(q_beats.size()), 32'd0);
    end else begin
      base = addr & ~32'h3;
      chk("beat_count", 32'(q_beats.size()), 32'(beats));
      chk("rd_count", 32'(q_rd.size()), we ? 32'd0 : 32'(beats));
      chk("done_count", 32'(q_done.size()), 32'd1);
      chk("no_timeout", 32'(to_cnt), 32'd0);
      if (q_beats.size() > 0) chk("first_ack_cyc", 32'(q_beats[0].cyc), 32'(acc + lat));
      for (int i = 0; i < q_beats.size() && i < beats; i++) begin
        ea = base + 32'(4 * i);
        ec = (len == 8'd0) ? 3'b000 : ((i == int'(len)) ? 3'b111 : 3'b010);
        chk("adr", q_beats[i].adr, ea);
        chk("cti", 32'(q_beats[i].cti), 32'(ec));
        chk("sel", 32'(q_beats[i].sel), 32'(sel));
        chk("we", 32'(q_beats[i].we), 32'(we));
        chk("pop", 32'(q_beats[i].pop), 32'(we));
        if (we) begin
          chk("wdat", q_beats[i].dat, wb + 32'(i));
        end else begin
          chk("wdat_rd", q_beats[i].dat, 32'd0);
          if (i < q_rd.size()) begin
            chk("rdat", q_rd[i], ea ^ xr);
            chk("rd_lat", 32'(q_rd_cyc[i]), 32'(q_beats[i].cyc + 1));
          end
        end
      end
      if (q_beats.size() == beats && q_done.size() == 1)
        chk("done_lat", 32'(q_done[0]), 32'(q_beats[beats-1].cyc + 1));
    end
    chk("ready_after", 32'(cmd_ready_o), 32'd1);
    chk("cyc_after", 32'(wb_cyc_o), 32'd0);
    chk("busy_after", 32'(busy_o), 32'd0);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [3:0]  sel;
    int          lat;
    logic [31:0] xr;
    logic [31:0] wb;
    logic [31:0] last_adr;
    logic [2:0]  last_cti;
  } vec_t;

  vec_t vt[6];

  initial begin
    int acc, g, bad_ready;
    logic seen;
    vt[0] = '{1'b1, 32'h0000_0100, 8'd0, 4'hF, 3,  32'h0,         32'hA5A5_0001, 32'h0000_0100, 3'b000};
    vt[1] = '{1'b0, 32'h0000_0200, 8'd7, 4'hF, 0,  32'h0,         32'h0,         32'h0000_021C, 3'b111};
    vt[2] = '{1'b1, 32'hFFFF_FFF8, 8'd3, 4'h3, 1,  32'h0,         32'h1234_0000, 32'h0000_0004, 3'b111};
    vt[3] = '{1'b0, 32'h0000_1003, 8'd1, 4'h8, 15, 32'hDEAD_BEEF, 32'h0,         32'h0000_1004, 3'b111};
    vt[4] = '{1'b1, 32'h0000_0040, 8'd0, 4'h5, 0,  32'h0,         32'hCAFE_0000, 32'h0000_0040, 3'b000};
    vt[5] = '{1'b0, 32'h0000_07F0, 8'd2, 4'h6, 2,  32'h0F0F_0F0F, 32'h0,         32'h0000_07F8, 3'b111};

    repeat (3) @(negedge clk);
    chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
    chk("rst_stb", 32'(wb_stb_o), 32'd0);
    chk("rst_we", 32'(wb_we_o), 32'd0);
    chk("rst_adr", wb_adr_o, 32'd0);
    chk("rst_sel", 32'(wb_sel_o), 32'd0);
    chk("rst_cti", 32'(wb_cti_o), 32'd0);
    chk("rst_rd_data", rd_data_o, 32'd0);
    chk("rst_rd_valid", 32'(rd_valid_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_timeout", 32'(timeout_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", 32'(cmd_ready_o), 32'd1);

    for (int i = 0; i < 6; i++) begin
      run_cmd(vt[i].we, vt[i].addr, vt[i].len, vt[i].sel, vt[i].lat, vt[i].xr, vt[i].wb);
      chk("tbl_nonempty", 32'(q_beats.size() != 0), 32'd1);
      if (q_beats.size() != 0) begin
        chk("tbl_last_adr", q_beats[q_beats.size()-1].adr, vt[i].last_adr);
        chk("tbl_last_cti", 32'(q_beats[q_beats.size()-1].cti), 32'(vt[i].last_cti));
      end
    end

    // Slave that never acknowledges.
    run_cmd(1'b1, 32'h0000_0800, 8'd3, 4'hF, 1000, 32'h0, 32'h5555_0000);

    // Asynchronous reset while beat 2 of a 6-beat write is on the bus.
    slv_lat = 0; wr_base = 32'h7700_0000; wr_req++;
    mon_clear();
    issue(1'b1, 32'h0000_0300, 8'd5, 4'hF, acc);
    g = 0;
    while (q_beats.size() < 2 && g < 100) begin
      @(negedge clk);
      #1;
      g++;
    end
    chk("rst_mid_reach", 32'(q_beats.size()), 32'd2);
    @(posedge clk);
    #2;
    chk("rst_mid_active", 32'({wb_cyc_o, wr_pop_o}), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_cyc", 32'(wb_cyc_o), 32'd0);
    chk("rst_mid_stb", 32'(wb_stb_o), 32'd0);
    chk("rst_mid_pop", 32'(wr_pop_o), 32'd0);
    chk("rst_mid_busy", 32'(busy_o), 32'd0);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_mid_no_done", 32'(q_done.size()), 32'd0);
    chk("rst_mid_no_to", 32'(to_cnt), 32'd0);
    rst_n = 1'b1;
    run_cmd(1'b0, 32'h0000_0300, 8'd3, 4'hF, 1, 32'h0000_00FF, 32'h0);

    // Second command held valid during the first transfer.
    slv_lat = 1; slv_xor = '0; wr_base = 32'h1111_0000; wr_req++;
    mon_clear();
    issue(1'b1, 32'h0000_0400, 8'd2, 4'hF, acc);
    cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_addr_i = 32'h0000_0500;
    cmd_len_i = 8'd1; cmd_sel_i = 4'h3;
    g = 0; bad_ready = 0; seen = 1'b0;
    while (!seen && g < 200) begin
      @(negedge clk);
      #1;
      g++;
      if (done_o) begin
        seen = 1'b1;
        chk("b2b_ready_in_done", 32'(cmd_ready_o), 32'd1);
      end else if (cmd_ready_o) begin
        bad_ready = 1;
      end
    end
    chk("b2b_done_seen", 32'(seen), 32'd1);
    chk("b2b_ready_low_busy", 32'(bad_ready), 32'd0);
    @(posedge clk);
    #1;
    cmd_valid_i = 1'b0;
    chk("b2b_cyc_next", 32'(wb_cyc_o), 32'd1);
    chk("b2b_we_next", 32'(wb_we_o), 32'd0);
    chk("b2b_adr_next", wb_adr_o, 32'h0000_0500);
    chk("b2b_cti_next", 32'(wb_cti_o), 32'b010);
    g = 0;
    while (q_done.size() < 2 && g < 200) begin
      @(negedge clk);
      #1;
      g++;
    end
    repeat (2) @(negedge clk);
    #1;
    chk("b2b_done_count", 32'(q_done.size()), 32'd2);
    chk("b2b_rd_count", 32'(q_rd.size()), 32'd2);
    if (q_rd.size() == 2) begin
      chk("b2b_rd0", q_rd[0], 32'h0000_0500);
      chk("b2b_rd1", q_rd[1], 32'h0000_0504);
    end

    for (int k = 0; k < 25; k++) begin
      logic        r_we;
      logic [7:0]  r_len;
      logic [3:0]  r_sel;
      r_we  = 1'($urandom_range(0, 1));
      r_len = 8'($urandom_range(0, 9));
      r_sel = 4'($urandom_range(0, 15));
      run_cmd(r_we, $urandom, r_len, r_sel, int'($urandom_range(0, 3)), $urandom, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
